// File: rtl/sprite_pixel_writer_if.sv
// Scanner / ROM / frame-buffer bundle for sprite_pixel_writer.
// master = environment side (scanner, sprite ROM, vga_adapter); slave = the writer.
interface sprite_pixel_writer_if;
  logic        in_valid;
  logic [8:0]  in_x;
  logic [7:0]  in_y;
  logic        in_last;
  logic        mirror;
  logic [13:0] rom_addr;
  logic [2:0]  rom_q;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        busy;
  logic        done;
  logic [14:0] plotted_count;

  modport master (
    output in_valid, in_x, in_y, in_last, mirror, rom_q,
    input  rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done, plotted_count
  );

  modport slave (
    input  in_valid, in_x, in_y, in_last, mirror, rom_q,
    output rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done, plotted_count
  );
endinterface

// File: rtl/sprite_pixel_writer.sv
// Sprite pixel writer: turns raster-ordered sprite coordinates into sprite ROM
// addresses (optionally mirrored), delays the coordinates to meet the ROM data,
// drops transparent / off-screen pixels and drives the vga_adapter write port.
module sprite_pixel_writer #(
  parameter int         SPRITE_W       = 80,
  parameter int         SPRITE_H       = 120,
  parameter int         ROM_LATENCY    = 2,
  parameter bit         TRANSPARENT_EN = 1'b1,
  parameter logic [2:0] KEY_COLOUR     = 3'b111
) (
  input logic                  clk,
  input logic                  reset,
  sprite_pixel_writer_if.slave bus
);

  localparam int COL_W = $clog2(SPRITE_W);
  localparam int ROW_W = $clog2(SPRITE_H);
  localparam int CNT_W = $clog2(ROM_LATENCY + 2);
  localparam logic [13:0]      W14     = 14'(SPRITE_W);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(SPRITE_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(SPRITE_H - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ROM_LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_drain_cnt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_accept;
  logic             w_first;
  logic             w_to_idle;

  logic             r_mir;
  logic             w_mir;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [13:0]      r_row_base;
  logic [13:0]      w_col_off;

  logic             r_vld_p [ROM_LATENCY];
  logic [8:0]       r_x_p   [ROM_LATENCY];
  logic [7:0]       r_y_p   [ROM_LATENCY];

  logic             w_plot;
  logic [8:0]       r_vga_x;
  logic [7:0]       r_vga_y;
  logic [2:0]       r_vga_colour;
  logic             r_vga_plot;
  logic [14:0]      r_plotted;

  function automatic logic [14:0] sat_inc15(input logic [14:0] v);
    return (v == 15'h7FFF) ? v : v + 15'd1;
  endfunction

  function automatic logic plot_ok(input logic vld, input logic [8:0] x,
                                   input logic [7:0] y, input logic [2:0] c);
    logic keyed;
    keyed = TRANSPARENT_EN && (c == KEY_COLOUR);
    return vld && (x < 9'd320) && (y < 8'd240) && !keyed;
  endfunction

  // State register plus drain timer (counts cycles spent in DRAIN).
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_done      <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + CNT_W'(1);
      else                    r_drain_cnt <= '0;
    end
  end

  // Next-state logic: accept pixels outside DRAIN, leave DRAIN once the last pixel is out.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = bus.in_last ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.in_valid) begin
          w_accept = 1'b1;
          if (bus.in_last) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == DRAIN_LAST) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_first   = (r_state == S_IDLE) && bus.in_valid;
  assign w_to_idle = (r_state != S_IDLE) && (w_state_nxt == S_IDLE);

  // Mirror request is captured with the first pixel and held for the whole sprite.
  always_ff @(posedge clk) begin
    if (!reset)       r_mir <= 1'b0;
    else if (w_first) r_mir <= bus.mirror;
  end

  // Column / row walk through the sprite; row_base tracks row*SPRITE_W without a multiplier.
  always_ff @(posedge clk) begin
    if (!reset || w_to_idle) begin
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
    end else if (w_accept) begin
      if (r_col == COL_MAX) begin
        r_col <= '0;
        if (r_row == ROW_MAX) begin
          r_row      <= '0;
          r_row_base <= '0;
        end else begin
          r_row      <= r_row + ROW_W'(1);
          r_row_base <= r_row_base + W14;
        end
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Stage p0 input: address is combinational so the ROM sees it in the accept cycle.
  assign w_mir        = (r_state == S_IDLE) ? bus.mirror : r_mir;
  assign w_col_off    = w_mir ? (14'(COL_MAX) - 14'(r_col)) : 14'(r_col);
  assign bus.rom_addr = r_row_base + w_col_off;

  // Valid chain, cleared on reset so in-flight pixels never reach the frame buffer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ROM_LATENCY; i++) r_vld_p[i] <= 1'b0;
    end else begin
      r_vld_p[0] <= w_accept;
      for (int i = 1; i < ROM_LATENCY; i++) r_vld_p[i] <= r_vld_p[i-1];
    end
  end

  // Coordinate chain, ROM_LATENCY deep so the tail lines up with rom_q.
  always_ff @(posedge clk) begin
    r_x_p[0] <= bus.in_x;
    r_y_p[0] <= bus.in_y;
    for (int i = 1; i < ROM_LATENCY; i++) begin
      r_x_p[i] <= r_x_p[i-1];
      r_y_p[i] <= r_y_p[i-1];
    end
  end

  // Stage p[ROM_LATENCY-1] -> output register: clip, colour-key, count writes.
  assign w_plot = plot_ok(r_vld_p[ROM_LATENCY-1], r_x_p[ROM_LATENCY-1],
                          r_y_p[ROM_LATENCY-1], bus.rom_q);

  // Output register towards vga_adapter and the per-sprite write counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_vga_plot   <= 1'b0;
      r_plotted    <= '0;
    end else begin
      r_vga_x      <= r_x_p[ROM_LATENCY-1];
      r_vga_y      <= r_y_p[ROM_LATENCY-1];
      r_vga_colour <= bus.rom_q;
      r_vga_plot   <= w_plot;
      if (w_first)     r_plotted <= '0;
      else if (w_plot) r_plotted <= sat_inc15(r_plotted);
    end
  end

  assign bus.vga_x         = r_vga_x;
  assign bus.vga_y         = r_vga_y;
  assign bus.vga_colour    = r_vga_colour;
  assign bus.vga_plot      = r_vga_plot;
  assign bus.plotted_count = r_plotted;
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.done          = r_done;

endmodule
